// File: rtl/csr_file_ext.sv
// Machine/user-mode CSR file: trap/mret sequencing, interrupt gating and 64-bit-capable counters.
// Reads are combinational on raddr; all state updates land on the next clk edge.
module csr_file_ext #(
    parameter int          NUM_HPM  = 2,
    parameter int          CNT_W    = 64,
    parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        raddr,
    output logic [31:0]        rdata,
    output logic               rd_illegal,
    input  logic [11:0]        waddr,
    input  logic [31:0]        wdata,
    input  logic               csr_w,
    input  logic [1:0]         csr_op,
    output logic               wr_illegal,
    input  logic               trap,
    input  logic [31:0]        trap_cause,
    input  logic [31:0]        trap_val,
    input  logic [31:0]        trap_pc,
    input  logic               mret,
    input  logic               instret,
    input  logic [NUM_HPM-1:0] hpm_event,
    input  logic               irq_ext,
    input  logic               irq_timer,
    output logic               irq_req,
    output logic [31:0]        irq_cause,
    output logic [31:0]        trap_target,
    output logic [31:0]        mepc,
    output logic [1:0]         priv
);

    localparam logic [1:0]       PRIV_M  = 2'b11;
    localparam logic [1:0]       PRIV_U  = 2'b00;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       priv_q, priv_d;
    logic             sts_mie_q, sts_mie_d;
    logic             sts_mpie_q, sts_mpie_d;
    logic [1:0]       sts_mpp_q, sts_mpp_d;
    logic [31:0]      mie_q, mie_d;
    logic [31:0]      mtvec_q, mtvec_d;
    logic [31:0]      mscratch_q, mscratch_d;
    logic [31:0]      mepc_q, mepc_d;
    logic [31:0]      mcause_q, mcause_d;
    logic [31:0]      mtval_q, mtval_d;
    logic [CNT_W-1:0] mcycle_q, mcycle_d;
    logic [CNT_W-1:0] minstret_q, minstret_d;
    logic [CNT_W-1:0] hpm_q [NUM_HPM];
    logic [CNT_W-1:0] hpm_d [NUM_HPM];

    logic [31:0] mstatus_rd, mip_rd, pending, wval;
    logic [32:0] rd_lk, wr_lk;
    logic        mret_ok, wr_en;

    assign mstatus_rd = {19'b0, sts_mpp_q, 3'b0, sts_mpie_q, 3'b0, sts_mie_q, 3'b0};
    assign mip_rd     = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};

    function automatic logic [31:0] lo32(input logic [CNT_W-1:0] c);
        logic [63:0] t;
        t = 64'(c);
        return t[31:0];
    endfunction

    // Zero-extension through 64 bits handles every CNT_W without zero-width replications.
    function automatic logic [31:0] hi32(input logic [CNT_W-1:0] c);
        logic [63:0] t;
        t = 64'(c);
        return t[63:32];
    endfunction

    function automatic logic [CNT_W-1:0] set_lo(input logic [CNT_W-1:0] c, input logic [31:0] w);
        logic [63:0] t;
        t = 64'(c);
        t[31:0] = w;
        return t[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] set_hi(input logic [CNT_W-1:0] c, input logic [31:0] w);
        logic [63:0] t;
        t = 64'(c);
        t[63:32] = w;
        return t[CNT_W-1:0];
    endfunction

    // Returns {implemented, value}; shared by the read port and read-modify-write path.
    function automatic logic [32:0] csr_lookup(input logic [11:0] a);
        logic [32:0] r;
        r = 33'b0;
        case (a)
            12'h300: r = {1'b1, mstatus_rd};
            12'h301: r = {1'b1, MISA_VAL};
            12'h304: r = {1'b1, mie_q};
            12'h305: r = {1'b1, mtvec_q};
            12'h340: r = {1'b1, mscratch_q};
            12'h341: r = {1'b1, mepc_q};
            12'h342: r = {1'b1, mcause_q};
            12'h343: r = {1'b1, mtval_q};
            12'h344: r = {1'b1, mip_rd};
            12'hB00, 12'hC00: r = {1'b1, lo32(mcycle_q)};
            12'hB80, 12'hC80: r = {1'b1, hi32(mcycle_q)};
            12'hB02, 12'hC02: r = {1'b1, lo32(minstret_q)};
            12'hB82, 12'hC82: r = {1'b1, hi32(minstret_q)};
            default: r = 33'b0;
        endcase
        for (int i = 0; i < NUM_HPM; i++) begin
            if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:0] == 7'(3 + i))
                r = {1'b1, a[7] ? hi32(hpm_q[i]) : lo32(hpm_q[i])};
        end
        return r;
    endfunction

    assign rd_lk      = csr_lookup(raddr);
    assign wr_lk      = csr_lookup(waddr);
    assign rd_illegal = ~rd_lk[32] | (raddr[9:8] > priv_q);
    assign rdata      = rd_illegal ? 32'b0 : rd_lk[31:0];
    assign wr_illegal = csr_w & (~wr_lk[32] | (waddr[11:10] == 2'b11) | (waddr[9:8] > priv_q));
    assign mret_ok    = mret & (priv_q == PRIV_M);
    assign wr_en      = csr_w & ~wr_illegal & (csr_op != 2'b00) & ~trap & ~mret_ok;

    always_comb begin
        wval = wr_lk[31:0];
        case (csr_op)
            2'b01:   wval = wdata;
            2'b10:   wval = wr_lk[31:0] | wdata;
            2'b11:   wval = wr_lk[31:0] & ~wdata;
            default: wval = wr_lk[31:0];
        endcase
    end

    always_comb begin
        priv_d     = priv_q;
        sts_mie_d  = sts_mie_q;
        sts_mpie_d = sts_mpie_q;
        sts_mpp_d  = sts_mpp_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (trap) begin
            mepc_d     = {trap_pc[31:2], 2'b00};
            mcause_d   = trap_cause;
            mtval_d    = trap_val;
            sts_mpie_d = sts_mie_q;
            sts_mie_d  = 1'b0;
            sts_mpp_d  = priv_q;
            priv_d     = PRIV_M;
        end else if (mret_ok) begin
            sts_mie_d  = sts_mpie_q;
            sts_mpie_d = 1'b1;
            priv_d     = sts_mpp_q;
            sts_mpp_d  = PRIV_U;
        end else if (wr_en) begin
            case (waddr)
                12'h300: begin
                    sts_mie_d  = wval[3];
                    sts_mpie_d = wval[7];
                    // Only M and U exist, so 01/10 leave MPP alone.
                    if (wval[12] == wval[11]) sts_mpp_d = wval[12:11];
                end
                12'h304: mie_d      = wval & 32'h0000_0880;
                12'h305: mtvec_d    = {wval[31:2], wval[1] ? 2'b00 : wval[1:0]};
                12'h340: mscratch_d = wval;
                12'h341: mepc_d     = {wval[31:2], 2'b00};
                12'h342: mcause_d   = wval;
                12'h343: mtval_d    = wval;
                default: ;
            endcase
        end
    end

    // A write to either counter half replaces that cycle's increment.
    always_comb begin
        mcycle_d = mcycle_q + CNT_ONE;
        if (wr_en && waddr == 12'hB00)      mcycle_d = set_lo(mcycle_q, wval);
        else if (wr_en && waddr == 12'hB80) mcycle_d = set_hi(mcycle_q, wval);
        minstret_d = minstret_q + CNT_W'(instret);
        if (wr_en && waddr == 12'hB02)      minstret_d = set_lo(minstret_q, wval);
        else if (wr_en && waddr == 12'hB82) minstret_d = set_hi(minstret_q, wval);
    end

    generate
        for (genvar gi = 0; gi < NUM_HPM; gi++) begin : g_hpm
            logic lo_we, hi_we;
            assign lo_we = wr_en & (waddr == 12'hB03 + 12'(gi));
            assign hi_we = wr_en & (waddr == 12'hB83 + 12'(gi));
            assign hpm_d[gi] = lo_we ? set_lo(hpm_q[gi], wval) :
                               hi_we ? set_hi(hpm_q[gi], wval) :
                                       hpm_q[gi] + CNT_W'(hpm_event[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            priv_q     <= PRIV_M;
            sts_mie_q  <= 1'b0;
            sts_mpie_q <= 1'b0;
            sts_mpp_q  <= 2'b00;
            mie_q      <= 32'b0;
            mtvec_q    <= 32'b0;
            mscratch_q <= 32'b0;
            mepc_q     <= 32'b0;
            mcause_q   <= 32'b0;
            mtval_q    <= 32'b0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            for (int i = 0; i < NUM_HPM; i++) hpm_q[i] <= '0;
        end else begin
            priv_q     <= priv_d;
            sts_mie_q  <= sts_mie_d;
            sts_mpie_q <= sts_mpie_d;
            sts_mpp_q  <= sts_mpp_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            for (int i = 0; i < NUM_HPM; i++) hpm_q[i] <= hpm_d[i];
        end
    end

    assign pending     = mip_rd & mie_q;
    assign irq_req     = (|pending) & (sts_mie_q | (priv_q == PRIV_U));
    assign irq_cause   = pending[11] ? 32'h8000_000B : 32'h8000_0007;
    assign trap_target = {mtvec_q[31:2], 2'b00} +
                         ((mtvec_q[0] & trap_cause[31]) ? {25'b0, trap_cause[4:0], 2'b00} : 32'b0);
    assign mepc        = mepc_q;
    assign priv        = priv_q;

endmodule

// File: tb/tb_csr_file_ext.sv
// Directed scenarios plus a randomized run against an architectural model of the CSR file.
module tb_csr_file_ext;
    logic        clk, rst;
    logic [11:0] raddr, waddr;
    logic [31:0] rdata, wdata, trap_cause, trap_val, trap_pc, irq_cause, trap_target, mepc;
    logic        rd_illegal, csr_w, wr_illegal, trap, mret, instret, irq_ext, irq_timer, irq_req;
    logic [1:0]  csr_op, priv, hpm_event;

    csr_file_ext dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rd_illegal(rd_illegal),
        .waddr(waddr), .wdata(wdata), .csr_w(csr_w), .csr_op(csr_op), .wr_illegal(wr_illegal),
        .trap(trap), .trap_cause(trap_cause), .trap_val(trap_val), .trap_pc(trap_pc),
        .mret(mret), .instret(instret), .hpm_event(hpm_event), .irq_ext(irq_ext),
        .irq_timer(irq_timer), .irq_req(irq_req), .irq_cause(irq_cause),
        .trap_target(trap_target), .mepc(mepc), .priv(priv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Architectural state of the model
    logic [1:0]  m_priv, m_mpp;
    logic        m_mie_s, m_mpie;
    logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ret;
    logic [63:0] m_hpm [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_priv = 2'b11; m_mpp = 2'b00; m_mie_s = 1'b0; m_mpie = 1'b0;
        m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_ret = 0; m_hpm[0] = 0; m_hpm[1] = 0;
    endtask

    function automatic void model_read(input logic [11:0] a, output logic impl, output logic [31:0] val);
        logic [63:0] c;
        impl = 1'b1;
        val  = 32'b0;
        c    = 64'b0;
        if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && (a[6:0] inside {7'd0, 7'd2, 7'd3, 7'd4})) begin
            case (a[6:0])
                7'd0:    c = m_cyc;
                7'd2:    c = m_ret;
                7'd3:    c = m_hpm[0];
                default: c = m_hpm[1];
            endcase
            val = a[7] ? c[63:32] : c[31:0];
        end else begin
            case (a)
                12'h300: val = (32'(m_mpp) << 11) | (32'(m_mpie) << 7) | (32'(m_mie_s) << 3);
                12'h301: val = 32'h4000_0100;
                12'h304: val = m_mie;
                12'h305: val = m_mtvec;
                12'h340: val = m_mscratch;
                12'h341: val = m_mepc;
                12'h342: val = m_mcause;
                12'h343: val = m_mtval;
                12'h344: val = (32'(irq_ext) << 11) | (32'(irq_timer) << 7);
                default: impl = 1'b0;
            endcase
        end
    endfunction

    function automatic logic write_ok(input logic [11:0] a);
        logic impl;
        logic [31:0] v;
        model_read(a, impl, v);
        return impl && (a[11:10] != 2'b11) && (a[9:8] <= m_priv);
    endfunction

    function automatic logic [63:0] put(input logic [63:0] c, input logic hi, input logic [31:0] v);
        return hi ? {v, c[31:0]} : {c[63:32], v};
    endfunction

    task automatic model_step();
        logic [63:0] cyc_n, ret_n, h0_n, h1_n;
        logic [31:0] old, nv;
        logic impl;
        cyc_n = m_cyc + 1;
        ret_n = m_ret + 64'(instret);
        h0_n  = m_hpm[0] + 64'(hpm_event[0]);
        h1_n  = m_hpm[1] + 64'(hpm_event[1]);
        if (trap) begin
            m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_val;
            m_mpie = m_mie_s; m_mie_s = 1'b0; m_mpp = m_priv; m_priv = 2'b11;
        end else if (mret && m_priv == 2'b11) begin
            m_mie_s = m_mpie; m_mpie = 1'b1; m_priv = m_mpp; m_mpp = 2'b00;
        end else if (csr_w && csr_op != 2'b00 && write_ok(waddr)) begin
            model_read(waddr, impl, old);
            nv = (csr_op == 2'b01) ? wdata : (csr_op == 2'b10) ? (old | wdata) : (old & ~wdata);
            if (waddr[11:8] == 4'hB) begin
                case (waddr[6:0])
                    7'd0:    cyc_n = put(m_cyc, waddr[7], nv);
                    7'd2:    ret_n = put(m_ret, waddr[7], nv);
                    7'd3:    h0_n  = put(m_hpm[0], waddr[7], nv);
                    default: h1_n  = put(m_hpm[1], waddr[7], nv);
                endcase
            end else begin
                case (waddr)
                    12'h300: begin
                        m_mie_s = nv[3]; m_mpie = nv[7];
                        if (nv[12:11] == 2'b00 || nv[12:11] == 2'b11) m_mpp = nv[12:11];
                    end
                    12'h304: m_mie = nv & 32'h880;
                    12'h305: m_mtvec = nv[1] ? (nv & ~32'h3) : nv;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & ~32'h3;
                    12'h342: m_mcause = nv;
                    12'h343: m_mtval = nv;
                    default: ;
                endcase
            end
        end
        m_cyc = cyc_n; m_ret = ret_n; m_hpm[0] = h0_n; m_hpm[1] = h1_n;
    endtask

    task automatic check_all();
        logic impl, exp_ill, pend_e, pend_t;
        logic [31:0] v, tgt;
        #1;
        model_read(raddr, impl, v);
        exp_ill = !impl || (raddr[9:8] > m_priv);
        chk("rd_illegal", 32'(rd_illegal), 32'(exp_ill));
        chk("rdata", rdata, exp_ill ? 32'b0 : v);
        chk("wr_illegal", 32'(wr_illegal), 32'(csr_w && !write_ok(waddr)));
        chk("priv", 32'(priv), 32'(m_priv));
        chk("mepc", mepc, m_mepc);
        pend_e = irq_ext && m_mie[11];
        pend_t = irq_timer && m_mie[7];
        chk("irq_req", 32'(irq_req), 32'((pend_e || pend_t) && (m_mie_s || m_priv == 2'b00)));
        chk("irq_cause", irq_cause, pend_e ? 32'h8000_000B : 32'h8000_0007);
        tgt = m_mtvec & ~32'h3;
        if (m_mtvec[0] && trap_cause[31]) tgt = tgt + 32'(trap_cause[4:0]) * 4;
        chk("trap_target", trap_target, tgt);
    endtask

    task automatic tick();
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic csrw(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_w = 1'b1; waddr = a; csr_op = op; wdata = d;
        tick();
        csr_w = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a);
        raddr = a;
        #1;
    endtask

    logic [11:0] addr_list [30];
    logic [31:0] saved;

    initial begin
        addr_list = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                      12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB83,
                      12'hB84, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hC03, 12'hC04, 12'hC83,
                      12'hC84, 12'hB05, 12'h302, 12'hC01, 12'h7C0, 12'hF11};
        rst = 1'b1; raddr = 0; waddr = 0; wdata = 0; csr_w = 0; csr_op = 0;
        trap = 0; trap_cause = 0; trap_val = 0; trap_pc = 0; mret = 0; instret = 0;
        hpm_event = 0; irq_ext = 0; irq_timer = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and free-running mcycle
        rd(12'hB00); chk("rst_mcycle", rdata, 32'd0);
        rd(12'h300); chk("rst_mstatus", rdata, 32'd0);
        repeat (10) tick();
        rd(12'hB00); chk("mcycle_10", rdata, 32'd10);
        rd(12'hB02); chk("minstret_0", rdata, 32'd0);
        chk("priv_m", 32'(priv), 32'h3);
        rd(12'h300); chk("rd_ill_300", 32'(rd_illegal), 32'd0);

        // Vectored interrupt entry
        csrw(12'h300, 2'b01, 32'h8);
        csrw(12'h305, 2'b01, 32'h1001);
        csrw(12'h304, 2'b01, 32'h800);
        irq_ext = 1'b1; #1;
        chk("irq_req_on", 32'(irq_req), 32'd1);
        chk("irq_cause_ext", irq_cause, 32'h8000_000B);
        trap = 1'b1; trap_cause = 32'h8000_000B; trap_pc = 32'h102; trap_val = 0; #1;
        chk("trap_target_vec", trap_target, 32'h102C);
        tick();
        trap = 1'b0;
        chk("mepc_trap", mepc, 32'h100);
        rd(12'h300); chk("mstatus_trap", rdata, 32'h1880);
        chk("irq_masked", 32'(irq_req), 32'd0);

        // Drop to U mode, privilege checks
        csrw(12'h300, 2'b01, 32'h80);
        mret = 1'b1; tick(); mret = 1'b0;
        chk("priv_u", 32'(priv), 32'h0);
        rd(12'h300); chk("u_rd_ill_300", 32'(rd_illegal), 32'd1); chk("u_rdata_0", rdata, 32'd0);
        rd(12'hC00); chk("u_rd_c00", 32'(rd_illegal), 32'd0);
        csr_w = 1'b1; waddr = 12'hB00; csr_op = 2'b01; wdata = 32'h1234; #1;
        chk("u_wr_ill_b00", 32'(wr_illegal), 32'd1);
        saved = m_cyc[31:0] + 32'd1;
        tick(); csr_w = 1'b0;
        rd(12'hC00); chk("mcycle_untouched", rdata, saved);
        trap = 1'b1; trap_cause = 32'h8; trap_pc = 32'h200; tick(); trap = 1'b0;
        irq_ext = 1'b0;
        chk("priv_back_m", 32'(priv), 32'h3);

        // 64-bit counter rollover
        csrw(12'hB00, 2'b01, 32'hFFFF_FFFF);
        csrw(12'hB80, 2'b01, 32'hFFFF_FFFF);
        rd(12'hB00); chk("mcycle_lo_ff", rdata, 32'hFFFF_FFFF);
        rd(12'hB80); chk("mcycle_hi_ff", rdata, 32'hFFFF_FFFF);
        tick();
        rd(12'hB00); chk("mcycle_lo_wrap", rdata, 32'h0);
        rd(12'hB80); chk("mcycle_hi_wrap", rdata, 32'h0);

        // trap beats mret beats csr write
        csrw(12'h340, 2'b01, 32'hA5A5);
        trap = 1; trap_cause = 32'h5; trap_val = 32'h77; trap_pc = 32'h333; mret = 1;
        csr_w = 1; waddr = 12'h340; csr_op = 2'b01; wdata = 32'hFFFF;
        tick();
        trap = 0; mret = 0; csr_w = 0;
        rd(12'h340); chk("prio_mscratch", rdata, 32'hA5A5);
        chk("prio_mepc", mepc, 32'h330);
        rd(12'h342); chk("prio_mcause", rdata, 32'h5);
        rd(12'h343); chk("prio_mtval", rdata, 32'h77);
        chk("prio_priv", 32'(priv), 32'h3);

        // Field masking and op semantics
        csrw(12'h304, 2'b01, 32'h880);
        csrw(12'h304, 2'b11, 32'h80);
        rd(12'h304); chk("mie_clear", rdata, 32'h800);
        csrw(12'h300, 2'b01, 32'h1800);
        csrw(12'h300, 2'b01, 32'h0800);
        rd(12'h300); chk("mpp_keep", rdata, 32'h1800);
        csrw(12'h305, 2'b01, 32'h12);
        rd(12'h305); chk("mtvec_mode", rdata, 32'h10);
        csrw(12'h341, 2'b01, 32'h7);
        rd(12'h341); chk("mepc_align", rdata, 32'h4);
        rd(12'h301); chk("misa", rdata, 32'h4000_0100);
        irq_timer = 1'b1;
        rd(12'h344); chk("mip_timer", rdata, 32'h80);
        irq_timer = 1'b0;

        // Randomized run
        for (int n = 0; n < 400; n++) begin
            raddr      = addr_list[$urandom_range(0, 29)];
            waddr      = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_list[$urandom_range(0, 29)];
            csr_w      = $urandom_range(0, 1) == 1;
            csr_op     = 2'($urandom);
            wdata      = $urandom;
            trap       = $urandom_range(0, 15) == 0;
            trap_cause = $urandom;
            trap_val   = $urandom;
            trap_pc    = $urandom;
            mret       = $urandom_range(0, 11) == 0;
            instret    = $urandom_range(0, 1) == 1;
            hpm_event  = 2'($urandom);
            irq_ext    = $urandom_range(0, 3) == 0;
            irq_timer  = $urandom_range(0, 3) == 0;
            tick();
        end
        trap = 0; mret = 0; csr_w = 0; instret = 0; hpm_event = 0; irq_ext = 0; irq_timer = 0;

        // Reset during a trap and write
        csr_w = 1; waddr = 12'h340; csr_op = 2'b01; wdata = 32'hDEAD;
        trap = 1; trap_pc = 32'h444; trap_cause = 32'h3;
        #1; rst = 1'b1; #1;
        chk("async_rst_mepc", mepc, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; csr_w = 0; trap = 0;
        model_reset();
        rd(12'h340); chk("rst_mscratch", rdata, 32'h0);
        rd(12'h342); chk("rst_mcause", rdata, 32'h0);
        chk("rst_priv", 32'(priv), 32'h3);
        repeat (3) tick();
        rd(12'hB00); chk("post_rst_mcycle", rdata, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
